// File: rtl/dram_cmd_pkg.sv
// Shared definitions for the DRAM responder: command set, pin positions, error codes.
// The command decoder turns raw controller pins into a single command per cycle.
package dram_cmd_pkg;

    localparam int unsigned DATA_W    = 64;
    localparam int unsigned ADDR_W    = 18;
    localparam int unsigned BANK_W    = 4;
    localparam int unsigned NUM_BANKS = 1 << BANK_W;
    localparam int unsigned ERR_W     = 3;

    localparam int unsigned RAS_BIT = 16;
    localparam int unsigned CAS_BIT = 15;
    localparam int unsigned WE_BIT  = 14;
    localparam int unsigned AP_BIT  = 10;

    localparam logic [ERR_W-1:0] ERR_NONE     = ERR_W'(0);
    localparam logic [ERR_W-1:0] ERR_ACT_OPEN = ERR_W'(1);
    localparam logic [ERR_W-1:0] ERR_CLOSED   = ERR_W'(2);
    localparam logic [ERR_W-1:0] ERR_TRCD     = ERR_W'(3);
    localparam logic [ERR_W-1:0] ERR_REF_OPEN = ERR_W'(4);
    localparam logic [ERR_W-1:0] ERR_BUSY     = ERR_W'(5);
    localparam logic [ERR_W-1:0] ERR_WATCHDOG = ERR_W'(6);

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_ACT,
        CMD_RD,
        CMD_WR,
        CMD_PRE,
        CMD_REF
    } cmd_e;

    // Unknown RAS/CAS/WE combinations fall through to NOP without flagging an error.
    function automatic cmd_e decode_cmd(input logic              cs1,
                                        input logic              active,
                                        input logic              refresh,
                                        input logic [ADDR_W-1:0] addr);
        logic [2:0] pins;
        pins = {addr[RAS_BIT], addr[CAS_BIT], addr[WE_BIT]};
        if (cs1)
            return CMD_NOP;
        if (!active)
            return CMD_ACT;
        if (refresh || pins == 3'b001)
            return CMD_REF;
        case (pins)
            3'b101:  return CMD_RD;
            3'b100:  return CMD_WR;
            3'b010:  return CMD_PRE;
            default: return CMD_NOP;
        endcase
    endfunction

endpackage

// File: rtl/dram_responder_if.sv
// Controller-to-DRAM pin bundle; the controller is the master, the responder the slave.
interface dram_responder_if;
    import dram_cmd_pkg::*;

    logic              cs1;
    logic              active;
    logic [1:0]        bank;
    logic [1:0]        bankgroup;
    logic [ADDR_W-1:0] addressram;
    logic              refresh;
    logic [DATA_W-1:0] ramdataout;
    logic [DATA_W-1:0] ramdatain;
    logic              rd_valid;
    logic              busy;
    logic              cmd_err;
    logic [ERR_W-1:0]  err_code;

    modport master (
        output cs1, active, bank, bankgroup, addressram, refresh, ramdataout,
        input  ramdatain, rd_valid, busy, cmd_err, err_code
    );

    modport slave (
        input  cs1, active, bank, bankgroup, addressram, refresh, ramdataout,
        output ramdatain, rd_valid, busy, cmd_err, err_code
    );

endinterface

// File: rtl/dram_read_pipe.sv
// CL-deep read-return delay line. The last data stage only loads on a valid entry,
// so the output data holds its previous value between reads.
module dram_read_pipe #(
    parameter int unsigned CL = 4,
    parameter int unsigned W  = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [CL-1:0] vld_q;
    logic [W-1:0]  dat_q [CL];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < CL; i++)
                dat_q[i] <= '0;
        end else begin
            vld_q[0] <= in_valid;
            if (in_valid)
                dat_q[0] <= in_data;
            for (int i = 1; i < CL; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1])
                    dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[CL-1];
    assign out_data  = dat_q[CL-1];

endmodule

// File: rtl/dram_responder.sv
// DRAM device stand-in: decodes controller pins, tracks per-bank open rows and timing,
// stores data, returns reads after CL and flags protocol errors. Optional refresh
// watchdog enabled by DRAM_REFRESH_WATCHDOG_EN.
module dram_responder
    import dram_cmd_pkg::*;
#(
    parameter int unsigned ROW_W = 3,
    parameter int unsigned COL_W = 4,
    parameter int unsigned CL    = 4,
    parameter int unsigned TRCD  = 3,
    parameter int unsigned TRFC  = 8,
    parameter int unsigned TREFI = 1024
) (
    input logic             clock,
    input logic             reset,
    dram_responder_if.slave bus
);

    localparam int unsigned TRCD_W = (TRCD > 1) ? $clog2(TRCD) : 1;
    localparam int unsigned RFC_W  = (TRFC > 1) ? $clog2(TRFC) : 1;
    localparam int unsigned MEM_AW = BANK_W + ROW_W + COL_W;
    localparam int unsigned DEPTH  = 1 << MEM_AW;

    cmd_e              cmd_c;
    logic [BANK_W-1:0] bidx_c;
    logic              ap_c;
    logic [COL_W-1:0]  col_c;
    logic [MEM_AW-1:0] widx_c;
    logic [DATA_W-1:0] rdata_c;
    logic [ERR_W-1:0]  err_c;
    logic              act_ok_c, rd_ok_c, wr_ok_c, pre_ok_c, ref_ok_c;
    logic              wd_err_c;
    logic              unused_c;

    logic [NUM_BANKS-1:0] bank_open;
    logic [ROW_W-1:0]     bank_row [NUM_BANKS];
    logic [TRCD_W-1:0]    trcd_q   [NUM_BANKS];
    logic                 busy_q;
    logic [RFC_W-1:0]     rfc_q;
    logic                 cmd_err_q;
    logic [ERR_W-1:0]     err_code_q;
    logic [DATA_W-1:0]    mem [DEPTH];

    assign cmd_c    = decode_cmd(bus.cs1, bus.active, bus.refresh, bus.addressram);
    assign bidx_c   = {bus.bankgroup, bus.bank};
    assign ap_c     = bus.addressram[AP_BIT];
    assign col_c    = bus.addressram[COL_W-1:0];
    assign widx_c   = {bidx_c, bank_row[bidx_c], col_c};
    assign rdata_c  = mem[widx_c];
    assign unused_c = ^bus.addressram;

    // Command legality check; at most one command per cycle so one error at most.
    always_comb begin
        act_ok_c = 1'b0;
        rd_ok_c  = 1'b0;
        wr_ok_c  = 1'b0;
        pre_ok_c = 1'b0;
        ref_ok_c = 1'b0;
        err_c    = ERR_NONE;
        if (busy_q && cmd_c != CMD_NOP) begin
            err_c = ERR_BUSY;
        end else begin
            case (cmd_c)
                CMD_ACT: begin
                    if (bank_open[bidx_c]) err_c    = ERR_ACT_OPEN;
                    else                   act_ok_c = 1'b1;
                end
                CMD_RD, CMD_WR: begin
                    if (!bank_open[bidx_c])
                        err_c = ERR_CLOSED;
                    else if (trcd_q[bidx_c] != '0)
                        err_c = ERR_TRCD;
                    else begin
                        rd_ok_c = (cmd_c == CMD_RD);
                        wr_ok_c = (cmd_c == CMD_WR);
                    end
                end
                CMD_PRE: pre_ok_c = 1'b1;
                CMD_REF: begin
                    if (|bank_open) err_c    = ERR_REF_OPEN;
                    else            ref_ok_c = 1'b1;
                end
                default: ;
            endcase
        end
        if (err_c == ERR_NONE && wd_err_c)
            err_c = ERR_WATCHDOG;
    end

    // Per-bank open state, open row and ACT-to-access countdown.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bank_open <= '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_row[i] <= '0;
                trcd_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BANKS; i++)
                if (trcd_q[i] != '0)
                    trcd_q[i] <= trcd_q[i] - TRCD_W'(1);
            if (act_ok_c) begin
                bank_open[bidx_c] <= 1'b1;
                bank_row[bidx_c]  <= bus.addressram[ROW_W-1:0];
                trcd_q[bidx_c]    <= TRCD_W'(TRCD - 1);
            end
            if ((rd_ok_c || wr_ok_c) && ap_c)
                bank_open[bidx_c] <= 1'b0;
            if (pre_ok_c) begin
                if (ap_c) bank_open         <= '0;
                else      bank_open[bidx_c] <= 1'b0;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (wr_ok_c)
            mem[widx_c] <= bus.ramdataout;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            rfc_q  <= '0;
        end else if (ref_ok_c) begin
            busy_q <= 1'b1;
            rfc_q  <= RFC_W'(TRFC - 1);
        end else if (busy_q) begin
            if (rfc_q == '0) busy_q <= 1'b0;
            else             rfc_q  <= rfc_q - RFC_W'(1);
        end
    end

`ifdef DRAM_REFRESH_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TREFI + 1);
    logic [WD_W-1:0] wd_q;

    // Cycles since the last accepted refresh, saturating at the interval.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            wd_q <= '0;
        else if (ref_ok_c)
            wd_q <= '0;
        else if (wd_q != WD_W'(TREFI))
            wd_q <= wd_q + WD_W'(1);
    end

    assign wd_err_c = (wd_q == WD_W'(TREFI));
`else
    logic wd_unused_c;
    assign wd_unused_c = ^32'(TREFI);
    assign wd_err_c    = 1'b0;
`endif

    // First error wins and sticks until reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmd_err_q  <= 1'b0;
            err_code_q <= ERR_NONE;
        end else if (!cmd_err_q && err_c != ERR_NONE) begin
            cmd_err_q  <= 1'b1;
            err_code_q <= err_c;
        end
    end

    dram_read_pipe #(
        .CL (CL),
        .W  (DATA_W)
    ) u_read_pipe (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (rd_ok_c),
        .in_data   (rdata_c),
        .out_valid (bus.rd_valid),
        .out_data  (bus.ramdatain)
    );

    assign bus.busy     = busy_q;
    assign bus.cmd_err  = cmd_err_q;
    assign bus.err_code = err_code_q;

endmodule

// File: doc/dram_responder.md
Name: dram_responder

Overview:
- Synthesizable DRAM-device stand-in on the RAM side of the memory controller, clocked by its ramclock.
- Decodes the controller's DDR4-style command pins (cs1, active, A16/A15/A14, A10).
- Tracks the open row in each of 16 banks, stores data in an internal array, and returns read data after a fixed CAS latency.
- Flags protocol violations so controller bugs show up in simulation and on FPGA.

Parameters:
- ROW_W, 3, row address bits actually stored (taken from addressram[ROW_W-1:0] at ACT).
- COL_W, 4, column bits stored (addressram[COL_W-1:0] at RD/WR, COL_W<=10).
- CL, 4, read latency in cycles from RD command to ramdatain valid (1..15).
- TRCD, 3, minimum cycles from ACT to RD/WR on the same bank.
- TRFC, 8, cycles the device is busy after REF.
- TREFI, 1024, refresh interval checked by the optional watchdog.

Ports:
- clock  input  1  ramclock from controller; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- cs1  input  1  chip select, active low; no command decoded when high.
- active  input  1  ACT_n, active low; low with cs1 low = ACTIVATE.
- bank  input  2  bank address.
- bankgroup  input  2  bank group; bank index = {bankgroup,bank}.
- addressram  input  18  row on ACT; on other commands A16=RAS_n, A15=CAS_n, A14=WE_n, A10=auto-precharge, A9:0=column.
- refresh  input  1  dedicated refresh strobe, active high; with cs1 low = REF.
- ramdataout  input  64  write data from controller, sampled in the WR command cycle.
- ramdatain  output  64  read data to controller.
- rd_valid  output  1  ramdatain carries RD data this cycle.
- busy  output  1  high during tRFC.
- cmd_err  output  1  sticky violation flag.
- err_code  output  3  code of first violation.

Behaviour:
- Reset: all banks closed, ramdatain=0, rd_valid=0, busy=0, cmd_err=0, err_code=0, counters 0. Memory contents are not cleared.
- Decode, only when cs1=0:
  - active=0 -> ACT.
  - refresh=1 or {A16,A15,A14}=001 -> REF.
  - 101 -> RD.
  - 100 -> WR.
  - 010 -> PRE; A10=1 means all banks.
  - 111 -> NOP.
  - Other codes -> NOP, no error.
- ACT: bank closed -> open with row=addressram[ROW_W-1:0] and load per-bank tRCD counter with TRCD-1. Bank already open -> error 1, state unchanged.
- RD/WR:
  - Bank closed -> error 2, ignored.
  - tRCD counter nonzero -> error 3, ignored.
  - Otherwise, word index = {bankgroup,bank,row,col}.
  - WR writes ramdataout in the same edge.
  - RD enters a CL-deep pipe; ramdatain/rd_valid asserted exactly CL cycles later for one cycle. ramdatain holds its last value otherwise.
  - A10=1 closes the bank after the access.
- Back-to-back RD every cycle is legal; the pipe carries one entry per stage.
- RD to an address written on the same edge returns the new data.
- PRE on a closed bank is legal (NOP).
- REF:
  - Any bank open -> error 4, ignored.
  - Otherwise busy=1 for TRFC cycles starting the next cycle.
  - Any non-NOP command while busy -> error 5, ignored.
  - REF while busy -> error 5, and the busy count is not restarted.
- Error latching: cmd_err sets on the first error and stays set until reset; err_code latches the first error only. Simultaneous decode yields at most one command, so no priority conflict exists.
- Reset mid-operation aborts the pipe: no rd_valid after reset deasserts.

Optional Feature:
- Macro DRAM_REFRESH_WATCHDOG_EN.
- When defined:
  - A counter increments each cycle and clears on an accepted REF.
  - Reaching TREFI sets cmd_err with err_code 6 (first-error rule applies).
  - The counter saturates at TREFI.
- When undefined: no counter logic; code 6 is never produced.

Decomposition:
- Package dram_cmd_pkg:
  - command enum (NOP, ACT, RD, WR, PRE, REF).
  - pin bit positions RAS_BIT=16, CAS_BIT=15, WE_BIT=14, AP_BIT=10.
  - error code constants 0..6.
  - bank-index width 4.
- Sub-module dram_read_pipe: CL-deep valid/data delay line with async reset of the valid bits.

Test Plan:
- Reset; ACT bank 0/group 0 row 5; wait 3 cycles; WR col 2 data 0xDEADBEEF_00000001; RD col 2 -> rd_valid exactly 4 cycles after RD with that data; cmd_err=0.
- RD to closed bank 3 group 1 -> cmd_err=1, err_code=2, no rd_valid; a later ACT on an open bank leaves err_code at 2.
- ACT then RD 1 cycle later (TRCD=3) -> err_code=3, no rd_valid.
- 4 back-to-back RDs cols 0..3 with distinct data -> 4 consecutive rd_valid cycles in order; a RD with A10=1 followed by RD to the same bank -> error 2.
- All banks closed; REF -> busy high 8 cycles; ACT on cycle 3 of busy -> err_code=5; REF with bank open -> err_code=4 in a fresh run.
- With DRAM_REFRESH_WATCHDOG_EN and TREFI=16: no REF for 16 cycles -> err_code=6. A REF every 10 cycles -> cmd_err stays 0.
